port_scoreboard: RTL and testbench
==================================

// Module: port_scoreboard
// PURPOSE
//  Per-port checker directly downstream of the command sniffer's 70-bit packet output.
//  Converts each packet into an expected response via the golden calc model and parks it in a tag-indexed table.
//  Matches each DUV response (resp/data/tag) against the parked entry; keeps pass/fail/timeout/error counts.
//  One instance per DUV port.
// PARAMETERS
//  PORT_ID     1     port number, used only in $display messages
//  TIMEOUT     64    cycles an entry may stay outstanding before it is declared lost
//  CNT_W       16    width of each statistics counter
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous, active-high
//  packet_in      in   70     {tag[69:68], cmd[67:64], data1[63:32], data2[31:0]}; all-zero when idle
//  out_resp_in    in   2      DUV response code; 0 = no response this cycle
//  out_data_in    in   32     DUV response data
//  out_tag_in     in   2      DUV response tag
//  outstanding    out  4      bit t set = tag t is awaiting a response
//  mismatch       out  1      one-cycle pulse on a compare failure
//  mismatch_tag   out  2      tag of the last mismatch
//  pass_count     out  CNT_W  matched responses
//  fail_count     out  CNT_W  mismatched responses
//  timeout_count  out  CNT_W  entries expired without a response
//  err_count      out  CNT_W  protocol errors (unexpected response or duplicate tag)
//  idle           out  1      high when outstanding == 0
// BEHAVIOUR
//  Reset: all outputs 0, except idle = 1. Table cleared. Reset mid-flight drops all entries; none are counted.
//  Capture: on each posedge with packet_in[67:64] != 0, write table[tag]. An entry holds exp_resp, exp_data, cmd and age.
//   Each command yields exactly one nonzero-cmd cycle on packet_in.
//  Golden model (33-bit internal arithmetic):
//   cmd 1 ADD: carry out -> resp 2, data 0; else resp 1, data = d1 + d2.
//   cmd 2 SUB: d2 > d1 -> resp 2, data 0; else resp 1, data = d1 - d2.
//   cmd 5 SHL: resp 1, data = d1 << d2[4:0].
//   cmd 6 SHR: resp 1, data = d1 >> d2[4:0].
//   Any other nonzero cmd: resp 2, data 0.
//  Duplicate tag: capture to an already-valid tag -> err_count+1, then the new entry overwrites the old one.
//  Response: on a posedge with out_resp_in != 0, look up out_tag_in.
//   Entry not valid -> err_count+1; no compare.
//   Valid entry: resp and data both equal -> pass_count+1. Otherwise fail_count+1, mismatch = 1 next cycle,
//    mismatch_tag = tag, and $display expected vs actual.
//   The entry is cleared in either case.
//   Data is compared only when exp_resp == 1.
//  Same cycle, same tag, capture and response: the response retires the OLD entry first (compare, counts),
//   then the new entry is written. No duplicate error is raised in this case.
//  Age: each valid entry increments age every cycle. When age == TIMEOUT-1, the entry is cleared and timeout_count+1.
//   Several tags expiring in one cycle each add 1 (add the popcount).
//   A response arriving in the expiry cycle wins; no timeout is counted.
//  Counters saturate at all-ones.
//  Latency: counters and outstanding update on the sampling edge; mismatch is a registered pulse, one cycle later.
// STRUCTURE
//  calc_tb_pkg (shared package): cmd_e {NOP=0, ADD=1, SUB=2, SHL=5, SHR=6}, resp_e {NONE=0, OK=1, ERR=2},
//   packet_t packed struct matching the 70-bit layout, function calc_expect(cmd, d1, d2).
//  Sub-module sb_tag_entry, instantiated x4: valid flag, expected fields, age counter.
//   It exposes a load/retire interface and an expire output.
//  Top level: capture decode, response compare, counter saturation and the mismatch register.
// TESTING
//  ADD tag0 d1=5 d2=7, DUV returns resp1 data 12 tag0 -> pass_count=1, outstanding=0000, mismatch stays 0.
//  ADD tag1 d1=FFFF_FFFF d2=1, DUV returns resp1 data 0 -> fail_count=1, mismatch pulse with mismatch_tag=1.
//  SHL tag2 d1=1 d2=35 (shift of 3), DUV returns resp1 data 8 -> pass.
//   Then cmd 3 tag3, DUV returns resp2 -> pass_count=2.
//  Four tags issued, no responses, TIMEOUT=64 -> timeout_count=4 at cycle 64 after capture; idle returns to 1.
//  Response on tag2 with nothing outstanding -> err_count=1.
//   Then tag0 captured twice without a response -> err_count=2.
//  Three tags outstanding, reset asserted for 1 cycle -> all counters 0, outstanding=0, idle=1;
//   late DUV responses then raise err_count.

Source files
------------

// File: rtl/port_scoreboard_pkg.sv
// Shared types and the golden calculator model used by the port scoreboard.
// calc_expect() turns one captured command into the response the DUV must return.
package port_scoreboard_pkg;

   typedef enum logic [3:0] {
      CmdNop = 4'd0,
      CmdAdd = 4'd1,
      CmdSub = 4'd2,
      CmdShl = 4'd5,
      CmdShr = 4'd6
   } cmd_e;

   typedef enum logic [1:0] {
      RespNone = 2'd0,
      RespOk   = 2'd1,
      RespErr  = 2'd2
   } resp_e;

   typedef struct packed {
      logic [1:0]  tag;
      logic [3:0]  cmd;
      logic [31:0] data1;
      logic [31:0] data2;
   } packet_t;

   typedef struct packed {
      logic [1:0]  resp;
      logic [31:0] data;
   } expect_t;

   localparam int unsigned NumTags = 4;

   function automatic expect_t calc_expect(input logic [3:0]  cmd,
                                           input logic [31:0] d1,
                                           input logic [31:0] d2);
      logic [32:0] wide;
      expect_t     e;
      wide   = '0;
      e.resp = RespErr;
      e.data = '0;
      case (cmd)
         CmdAdd: begin
            wide = {1'b0, d1} + {1'b0, d2};
            if (!wide[32]) begin
               e.resp = RespOk;
               e.data = wide[31:0];
            end
         end
         CmdSub: begin
            // Borrow out of the 33-bit difference means d2 > d1.
            wide = {1'b0, d1} - {1'b0, d2};
            if (!wide[32]) begin
               e.resp = RespOk;
               e.data = wide[31:0];
            end
         end
         CmdShl: begin
            e.resp = RespOk;
            e.data = d1 << d2[4:0];
         end
         CmdShr: begin
            e.resp = RespOk;
            e.data = d1 >> d2[4:0];
         end
         default: ;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/port_scoreboard_entry.sv
// One tag slot of the scoreboard: parked expected response plus an age counter.
// load wins over retire/expire so a same-cycle reuse keeps the new entry.
module port_scoreboard_entry
   import port_scoreboard_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    load,
   input  expect_t load_exp,
   input  logic    retire,
   output logic    valid,
   output expect_t exp_val,
   output logic    expire
);

   localparam int unsigned AgeW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic            valid_q, valid_d;
   logic [AgeW-1:0] age_q, age_d;
   expect_t         exp_q, exp_d;

   always_comb begin
      expire  = valid_q && (age_q == AgeW'(TIMEOUT - 1));
      valid_d = valid_q;
      age_d   = age_q;
      exp_d   = exp_q;
      if (load) begin
         valid_d = 1'b1;
         age_d   = '0;
         exp_d   = load_exp;
      end else if (retire || expire) begin
         valid_d = 1'b0;
         age_d   = '0;
      end else if (valid_q) begin
         age_d = age_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         age_q   <= '0;
         exp_q   <= '0;
      end else begin
         valid_q <= valid_d;
         age_q   <= age_d;
         exp_q   <= exp_d;
      end
   end

   assign valid   = valid_q;
   assign exp_val = exp_q;

endmodule

// File: rtl/port_scoreboard.sv
// Per-port response checker: parks golden-model expectations by tag and scores DUV responses.
// Keeps saturating pass/fail/timeout/error counters and a registered mismatch pulse.
module port_scoreboard
   import port_scoreboard_pkg::*;
#(
   parameter int unsigned PORT_ID = 1,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [69:0]      packet_in,
   input  logic [1:0]       out_resp_in,
   input  logic [31:0]      out_data_in,
   input  logic [1:0]       out_tag_in,
   output logic [3:0]       outstanding,
   output logic             mismatch,
   output logic [1:0]       mismatch_tag,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic [CNT_W-1:0] timeout_count,
   output logic [CNT_W-1:0] err_count,
   output logic             idle
);

   if (TIMEOUT < 2 || CNT_W < 2) begin : g_bad_params
      $error("port_scoreboard %0d: TIMEOUT and CNT_W must be at least 2", PORT_ID);
   end

   packet_t              pkt;
   expect_t              cap_exp;
   expect_t              exp_val [NumTags];
   logic [NumTags-1:0]   load, retire, valid, expire, timed_out;
   logic                 capture, resp_seen, hit, match, dup;
   logic [2:0]           err_inc, tmo_inc;
   logic [CNT_W-1:0]     pass_q, fail_q, tmo_q, err_q;
   logic                 mismatch_q;
   logic [1:0]           mismatch_tag_q;

   assign pkt = packet_in;

   for (genvar t = 0; t < NumTags; t++) begin : g_tag
      port_scoreboard_entry #(
         .TIMEOUT (TIMEOUT)
      ) u_entry (
         .clk      (clk),
         .reset    (reset),
         .load     (load[t]),
         .load_exp (cap_exp),
         .retire   (retire[t]),
         .valid    (valid[t]),
         .exp_val  (exp_val[t]),
         .expire   (expire[t])
      );
   end

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [2:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt} + (CNT_W + 1)'(inc);
      return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   endfunction

   always_comb begin
      capture   = pkt.cmd != CmdNop;
      cap_exp   = calc_expect(pkt.cmd, pkt.data1, pkt.data2);
      resp_seen = out_resp_in != RespNone;
      hit       = resp_seen && valid[out_tag_in];
      // Data only matters when the expected response carries a result.
      match     = (out_resp_in == exp_val[out_tag_in].resp) &&
                  ((exp_val[out_tag_in].resp != RespOk) ||
                   (out_data_in == exp_val[out_tag_in].data));
      load      = '0;
      retire    = '0;
      tmo_inc   = '0;
      for (int t = 0; t < NumTags; t++) begin
         load[t]   = capture && (pkt.tag == 2'(t));
         retire[t] = hit && (out_tag_in == 2'(t));
      end
      // A response in the expiry cycle retires the entry instead of timing it out.
      timed_out = expire & ~retire;
      for (int t = 0; t < NumTags; t++) begin
         tmo_inc = tmo_inc + 3'(timed_out[t]);
      end
      dup     = capture && valid[pkt.tag] && !retire[pkt.tag] && !expire[pkt.tag];
      err_inc = 3'(resp_seen && !hit) + 3'(dup);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pass_q         <= '0;
         fail_q         <= '0;
         tmo_q          <= '0;
         err_q          <= '0;
         mismatch_q     <= 1'b0;
         mismatch_tag_q <= '0;
      end else begin
         pass_q     <= sat_add(pass_q, 3'(hit && match));
         fail_q     <= sat_add(fail_q, 3'(hit && !match));
         tmo_q      <= sat_add(tmo_q, tmo_inc);
         err_q      <= sat_add(err_q, err_inc);
         mismatch_q <= hit && !match;
         if (hit && !match) begin
            mismatch_tag_q <= out_tag_in;
         end
      end
   end

   assign outstanding   = valid;
   assign idle          = ~|valid;
   assign mismatch      = mismatch_q;
   assign mismatch_tag  = mismatch_tag_q;
   assign pass_count    = pass_q;
   assign fail_count    = fail_q;
   assign timeout_count = tmo_q;
   assign err_count     = err_q;

endmodule

// File: tb/tb_port_scoreboard.sv
// Directed bench for port_scoreboard: stimulus queues expected counter snapshots and
// mismatch tags; an independent monitor pops and compares whenever the DUT outputs change.
module tb_port_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic [69:0] packet_in;
   logic [1:0]  out_resp_in;
   logic [31:0] out_data_in;
   logic [1:0]  out_tag_in;
   logic [3:0]  outstanding;
   logic        mismatch;
   logic [1:0]  mismatch_tag;
   logic [15:0] pass_count, fail_count, timeout_count, err_count;
   logic        idle;

   always #5 clk = ~clk;

   port_scoreboard #(
      .PORT_ID (1),
      .TIMEOUT (64),
      .CNT_W   (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .packet_in     (packet_in),
      .out_resp_in   (out_resp_in),
      .out_data_in   (out_data_in),
      .out_tag_in    (out_tag_in),
      .outstanding   (outstanding),
      .mismatch      (mismatch),
      .mismatch_tag  (mismatch_tag),
      .pass_count    (pass_count),
      .fail_count    (fail_count),
      .timeout_count (timeout_count),
      .err_count     (err_count),
      .idle          (idle)
   );

   typedef struct packed {
      logic [15:0] p;
      logic [15:0] f;
      logic [15:0] t;
      logic [15:0] e;
   } cnt_t;

   int         checks   = 0;
   int         failures = 0;
   cnt_t       exp_q[$];
   logic [1:0] mtag_q[$];
   cnt_t       model;
   cnt_t       last;
   bit         mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every change of the counter bank and every mismatch pulse consumes one expectation.
   always @(negedge clk) begin
      cnt_t cur;
      cnt_t e;
      if (mon_en) begin
         cur = {pass_count, fail_count, timeout_count, err_count};
         if (cur !== last) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL counters_unexpected: got %0h expected no change from %0h", cur, last);
            end else begin
               e = exp_q.pop_front();
               check("counters{pass,fail,tmo,err}", cur, e);
            end
            last = cur;
         end
         if (mismatch !== 1'b0) begin
            if (mtag_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL mismatch_unexpected: got mismatch=%b tag=%0d expected no pulse",
                        mismatch, mismatch_tag);
            end else begin
               check("mismatch_tag", 64'(mismatch_tag), 64'(mtag_q.pop_front()));
            end
         end
      end
   end

   task automatic push_counts();
      exp_q.push_back(model);
   endtask

   task automatic send_pkt(input logic [1:0] tag, input logic [3:0] cmd,
                           input logic [31:0] d1, input logic [31:0] d2);
      packet_in = {tag, cmd, d1, d2};
      @(posedge clk);
      #1;
      packet_in = '0;
   endtask

   task automatic send_resp(input logic [1:0] tag, input logic [1:0] resp, input logic [31:0] data);
      out_tag_in  = tag;
      out_resp_in = resp;
      out_data_in = data;
      @(posedge clk);
      #1;
      out_resp_in = '0;
      out_data_in = '0;
      out_tag_in  = '0;
   endtask

   task automatic send_both(input logic [1:0] tag, input logic [3:0] cmd, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [1:0] resp, input logic [31:0] data);
      packet_in   = {tag, cmd, d1, d2};
      out_tag_in  = tag;
      out_resp_in = resp;
      out_data_in = data;
      @(posedge clk);
      #1;
      packet_in   = '0;
      out_resp_in = '0;
      out_data_in = '0;
      out_tag_in  = '0;
   endtask

   initial begin
      reset       = 1'b1;
      packet_in   = '0;
      out_resp_in = '0;
      out_data_in = '0;
      out_tag_in  = '0;
      model       = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_outstanding", 64'(outstanding), 64'h0);
      check("reset_idle", 64'(idle), 64'h1);
      check("reset_counters", {pass_count, fail_count, timeout_count, err_count}, 64'h0);
      check("reset_mismatch", 64'(mismatch), 64'h0);
      last   = '0;
      mon_en = 1'b1;

      // ADD 5+7 = 12, correct reply.
      send_pkt(2'd0, 4'd1, 32'd5, 32'd7);
      check("add_outstanding", 64'(outstanding), 64'h1);
      check("add_busy", 64'(idle), 64'h0);
      model.p += 1; push_counts();
      send_resp(2'd0, 2'd1, 32'd12);
      check("add_retired", 64'(outstanding), 64'h0);
      check("add_no_mismatch", 64'(mismatch), 64'h0);

      // ADD with carry out expects ERR; DUV claims OK.
      send_pkt(2'd1, 4'd1, 32'hFFFF_FFFF, 32'd1);
      model.f += 1; push_counts(); mtag_q.push_back(2'd1);
      send_resp(2'd1, 2'd1, 32'd0);
      check("fail_pulse", 64'(mismatch), 64'h1);
      check("fail_pulse_tag", 64'(mismatch_tag), 64'h1);
      @(posedge clk); #1;
      check("fail_pulse_end", 64'(mismatch), 64'h0);

      // SHL by 35 uses only the low 5 bits: 1 << 3 = 8.
      send_pkt(2'd2, 4'd5, 32'd1, 32'd35);
      model.p += 1; push_counts();
      send_resp(2'd2, 2'd1, 32'd8);
      // Undefined cmd 3 expects ERR.
      send_pkt(2'd3, 4'd3, 32'd9, 32'd9);
      model.p += 1; push_counts();
      send_resp(2'd3, 2'd2, 32'd0);
      // SUB 10-3 = 7.
      send_pkt(2'd0, 4'd2, 32'd10, 32'd3);
      model.p += 1; push_counts();
      send_resp(2'd0, 2'd1, 32'd7);
      // SUB 3-10 underflows -> ERR; data ignored for ERR responses.
      send_pkt(2'd1, 4'd2, 32'd3, 32'd10);
      model.p += 1; push_counts();
      send_resp(2'd1, 2'd2, 32'd1234);
      // SHR 0x8000_0000 >> 31 = 1; DUV returns 2.
      send_pkt(2'd2, 4'd6, 32'h8000_0000, 32'd31);
      model.f += 1; push_counts(); mtag_q.push_back(2'd2);
      send_resp(2'd2, 2'd1, 32'd2);
      // Right data but wrong response code.
      send_pkt(2'd3, 4'd1, 32'd5, 32'd7);
      model.f += 1; push_counts(); mtag_q.push_back(2'd3);
      send_resp(2'd3, 2'd2, 32'd12);
      repeat (2) @(posedge clk); #1;

      // Four tags, no responses: each expires 64 cycles after its capture.
      for (int i = 0; i < 4; i++) begin
         model.t += 1; push_counts();
      end
      for (int i = 0; i < 4; i++) begin
         send_pkt(2'(i), 4'd1, 32'(i), 32'd1);
      end
      repeat (60) @(posedge clk);
      #1;
      check("tmo_age63_still_held", 64'(outstanding), 64'hF);
      @(posedge clk); #1;
      check("tmo_tag0_expired", 64'(outstanding), 64'hE);
      repeat (3) @(posedge clk); #1;
      check("tmo_all_expired", 64'(outstanding), 64'h0);
      check("tmo_idle", 64'(idle), 64'h1);

      // Response arriving in the expiry cycle is scored, not timed out.
      send_pkt(2'd0, 4'd1, 32'd1, 32'd1);
      repeat (63) @(posedge clk);
      #1;
      model.p += 1; push_counts();
      send_resp(2'd0, 2'd1, 32'd2);
      check("race_retired", 64'(outstanding), 64'h0);

      // Unexpected response, then a duplicate capture that overwrites the entry.
      model.e += 1; push_counts();
      send_resp(2'd2, 2'd1, 32'd0);
      send_pkt(2'd0, 4'd1, 32'd1, 32'd2);
      model.e += 1; push_counts();
      send_pkt(2'd0, 4'd1, 32'd3, 32'd4);
      model.p += 1; push_counts();
      send_resp(2'd0, 2'd1, 32'd7);

      // Same-cycle capture and response on one tag: old entry retired, new one parked.
      send_pkt(2'd1, 4'd1, 32'd2, 32'd3);
      model.p += 1; push_counts();
      send_both(2'd1, 4'd1, 32'd10, 32'd20, 2'd1, 32'd5);
      check("same_cycle_reparked", 64'(outstanding), 64'h2);
      model.p += 1; push_counts();
      send_resp(2'd1, 2'd1, 32'd30);

      // Mid-flight reset drops everything; late replies become protocol errors.
      send_pkt(2'd0, 4'd1, 32'd1, 32'd1);
      send_pkt(2'd1, 4'd2, 32'd5, 32'd1);
      send_pkt(2'd2, 4'd5, 32'd1, 32'd1);
      check("pre_reset_outstanding", 64'(outstanding), 64'h7);
      model = '0; push_counts();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midreset_outstanding", 64'(outstanding), 64'h0);
      check("midreset_idle", 64'(idle), 64'h1);
      check("midreset_counters", {pass_count, fail_count, timeout_count, err_count}, 64'h0);
      model.e += 1; push_counts();
      send_resp(2'd0, 2'd1, 32'd2);
      model.e += 1; push_counts();
      send_resp(2'd1, 2'd1, 32'd4);
      model.e += 1; push_counts();
      send_resp(2'd2, 2'd1, 32'd2);

      repeat (4) @(posedge clk); #1;
      check("counter_events_left", 64'(exp_q.size()), 64'h0);
      check("mismatch_events_left", 64'(mtag_q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
